// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   hazard_state_t : load-use stall FSM state (IDLE, LD_STALL)
//   REG_ZERO       : register specifier of $zero, which never creates a hazard
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        LD_STALL = 1'b1
    } hazard_state_t;

    localparam logic [31:0] REG_ZERO = '0;

endpackage

// File: rtl/hazard_lat_counter.sv
// -----------------------------------------------------------------------------
// hazard_lat_counter
// Down counter: synchronous clear, load, otherwise decrement and hold at 0.
// Width is sized to hold values 0..N.
// Ports:
//   clk       in   pipeline clock
//   rst       in   asynchronous active-high reset (count -> 0)
//   clear     in   force count to 0 (highest priority after reset)
//   load      in   load load_val
//   load_val  in   value to load
//   cnt       out  current count
// -----------------------------------------------------------------------------
module hazard_lat_counter #(
    parameter  int N = 1,
    localparam int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush controller beside the ID stage of a 5-stage MIPS pipeline.
// Detects load-use hazards (stall of LOAD_LAT cycles) and HI/LO hazards
// against a multi-cycle mult/div unit, and flushes on taken branch / jump.
// Flush always overrides stall.
//
// Optional feature: define HAZ_PERF_CNT_EN to add the stall_cycles and
// flush_count performance counters (32-bit, wrapping, cleared by rst).
//
// Ports:
//   clk, rst             clock, async active-high reset (outputs 0 while high)
//   if_id_rs, if_id_rt   source specifiers of the instruction in ID
//   id_ex_rt             destination rt of the instruction in EX
//   id_ex_mem_read       instruction in EX is a load
//   if_id_uses_hilo      instruction in ID reads HI/LO
//   md_start             mult/div issued this cycle
//   branch_taken, jump   control transfer resolved this cycle
//   pc_write_disable     hold PC
//   if_id_write_disable  hold IF/ID
//   id_ex_bubble         zero the controls entering ID/EX
//   if_id_flush          clear IF/ID
//   id_ex_flush          clear ID/EX (only when FLUSH_ID_EX != 0)
//   stall_cycles         (HAZ_PERF_CNT_EN) cycles with stall outputs asserted
//   flush_count          (HAZ_PERF_CNT_EN) cycles with flush asserted
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int LOAD_LAT    = 1,
    parameter int MD_LAT      = 8,
    parameter int FLUSH_ID_EX = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic                  id_ex_mem_read,
    input  logic                  if_id_uses_hilo,
    input  logic                  md_start,
    input  logic                  branch_taken,
    input  logic                  jump,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count,
`endif
    output logic                  pc_write_disable,
    output logic                  if_id_write_disable,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic                  id_ex_flush
);

    localparam int LD_W = $clog2(LOAD_LAT + 1);
    localparam int MD_W = $clog2(MD_LAT + 1);
    localparam logic [LD_W-1:0] LD_LOAD_VAL = LD_W'(LOAD_LAT - 1);
    // The issue cycle itself is the first of the MD_LAT cycles, so the
    // counter only has to cover the MD_LAT-1 cycles that follow it.
    localparam logic [MD_W-1:0] MD_LOAD_VAL = MD_W'(MD_LAT - 1);

    hazard_state_t   state, state_nxt;
    logic [LD_W-1:0] ld_cnt;
    logic [MD_W-1:0] md_cnt;
    logic            lu, flush, hilo, stall, stall_eff, ld_load;

    assign lu = id_ex_mem_read
              & (id_ex_rt != REG_ZERO[REG_ADDR_W-1:0])
              & ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));

    assign flush   = branch_taken | jump;
    assign ld_load = (state == IDLE) & lu & ~flush & (LOAD_LAT > 1);

    hazard_lat_counter #(.N(LOAD_LAT)) u_ld_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .load     (ld_load),
        .load_val (LD_LOAD_VAL),
        .cnt      (ld_cnt)
    );

    hazard_lat_counter #(.N(MD_LAT)) u_md_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (1'b0),
        .load     (md_start),
        .load_val (MD_LOAD_VAL),
        .cnt      (md_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ld_load) begin
                    state_nxt = LD_STALL;
                end
            end
            LD_STALL: begin
                if (flush || (ld_cnt == LD_W'(1))) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign hilo  = (md_cnt != '0) & if_id_uses_hilo;
    assign stall = (lu & (state == IDLE)) | (state == LD_STALL) | hilo;

    // Gating with rst makes every output drop the moment reset is applied.
    assign stall_eff           = stall & ~flush & ~rst;
    assign pc_write_disable    = stall_eff;
    assign if_id_write_disable = stall_eff;
    assign id_ex_bubble        = stall_eff;
    assign if_id_flush         = flush & ~rst;
    assign id_ex_flush         = flush & ~rst & (FLUSH_ID_EX != 0);

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall & ~flush) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule
